// File: rtl/id_stage.sv
// id_stage: LA32R decode stage with one-entry pipeline register, register-file read
// and branch resolution feeding a redirect back to fetch.
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C000000,
    parameter int          ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [63:0]         in_bus,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [4:0]          rf_raddr1,
    output logic [4:0]          rf_raddr2,
    input  logic [31:0]         rf_rdata1,
    input  logic [31:0]         rf_rdata2,
    input  logic                hazard_stall,
    output logic                is_branch,
    output logic                flush,
    output logic [31:0]         dnpc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_pc,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [31:0]         out_src1,
    output logic [31:0]         out_src2,
    output logic [31:0]         out_st_data,
    output logic [4:0]          out_rd,
    output logic                out_rf_we,
    output logic                out_mem_re,
    output logic                out_mem_we,
    output logic                out_illegal
);
    logic        valid_q;
    logic [63:0] bus_q;
    logic [31:0] pc, inst, sext12, off16, off26, target;
    logic        out_fire, capture, taken, eq;
    logic        i_add, i_sub, i_addi, i_ld, i_st, i_lu12i, i_b, i_bl, i_beq, i_bne, i_jirl;
    assign pc       = bus_q[63:32];
    assign inst     = bus_q[31:0];
    assign out_fire = out_valid & out_ready;
    assign in_ready = ~valid_q | out_fire;
    assign capture  = in_valid & in_ready & ~flush;
    assign out_valid = valid_q & ~hazard_stall;
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            bus_q   <= '0;
        end else if (capture) begin
            valid_q <= 1'b1;
            bus_q   <= in_bus;
        end else if (out_fire) begin
            valid_q <= 1'b0;
        end
    end
    assign i_add   = inst[31:15] == 17'h20;
    assign i_sub   = inst[31:15] == 17'h22;
    assign i_addi  = inst[31:22] == 10'h00A;
    assign i_ld    = inst[31:22] == 10'h0A2;
    assign i_st    = inst[31:22] == 10'h0A6;
    assign i_lu12i = inst[31:25] == 7'h0A;
    assign i_b     = inst[31:26] == 6'h14;
    assign i_bl    = inst[31:26] == 6'h15;
    assign i_beq   = inst[31:26] == 6'h16;
    assign i_bne   = inst[31:26] == 6'h17;
    assign i_jirl  = inst[31:26] == 6'h13;
    assign sext12 = {{20{inst[21]}}, inst[21:10]};
    assign off16  = {{14{inst[25]}}, inst[25:10], 2'b00};
    assign off26  = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    assign rf_raddr1 = inst[9:5];
    // stores and compares read rd through port 2 instead of rk
    assign rf_raddr2 = (i_st | i_beq | i_bne) ? inst[4:0] : inst[14:10];
    assign eq     = rf_rdata1 == rf_rdata2;
    assign taken  = i_b | i_bl | i_jirl | (i_beq & eq) | (i_bne & ~eq);
    assign target = (i_jirl ? rf_rdata1 : pc) + ((i_b | i_bl) ? off26 : off16);
    assign is_branch = out_fire & taken;
    assign flush     = is_branch;
    assign dnpc      = valid_q ? target : RESET_PC;
    always_comb begin
        out_pc      = valid_q ? pc : RESET_PC;
        out_alu_op  = i_sub ? ALU_OP_W'(1) : (i_lu12i | i_bl | i_jirl) ? ALU_OP_W'(2) : ALU_OP_W'(0);
        out_src1    = rf_rdata1;
        out_src2    = (i_addi | i_ld | i_st) ? sext12 :
                      i_lu12i ? {inst[24:5], 12'b0} :
                      (i_bl | i_jirl) ? pc + 32'd4 : rf_rdata2;
        out_st_data = rf_rdata2;
        out_rd      = i_bl ? 5'd1 : inst[4:0];
        out_rf_we   = i_add | i_sub | i_addi | i_ld | i_lu12i | i_bl | i_jirl;
        out_mem_re  = i_ld;
        out_mem_we  = i_st;
        out_illegal = ~(i_add | i_sub | i_addi | i_ld | i_st | i_lu12i | i_b | i_bl | i_beq | i_bne | i_jirl);
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized scoreboard bench for id_stage against an instruction-level
// reference model and a behavioural register file.
module tb_id_stage;
    localparam logic [31:0] RESET_PC = 32'h1C000000;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, hazard_stall, is_branch, flush, out_valid, out_ready;
    logic [63:0] in_bus;
    logic [4:0]  rf_raddr1, rf_raddr2, out_rd;
    logic [31:0] rf_rdata1, rf_rdata2, dnpc, out_pc, out_src1, out_src2, out_st_data;
    logic [3:0]  out_alu_op;
    logic        out_rf_we, out_mem_re, out_mem_we, out_illegal;
    logic [31:0] regs [32];
    logic [63:0] q [$];
    int          checks = 0, errors = 0;
    bit          armed = 0, acc, drp;

    always #5 clk = ~clk;
    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    id_stage #(.RESET_PC(RESET_PC), .ALU_OP_W(4)) dut (
        .clk(clk), .reset(reset), .in_bus(in_bus), .in_valid(in_valid), .in_ready(in_ready),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .hazard_stall(hazard_stall), .is_branch(is_branch), .flush(flush), .dnpc(dnpc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_alu_op(out_alu_op),
        .out_src1(out_src1), .out_src2(out_src2), .out_st_data(out_st_data), .out_rd(out_rd),
        .out_rf_we(out_rf_we), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
        .out_illegal(out_illegal)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] s1, s2, sd, tgt;
        logic [4:0]  a1, a2, rd;
        logic        we, re, wm, ill, tk, c2;
    } exp_t;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    function automatic exp_t ref_model(input logic [63:0] b);
        exp_t e;
        logic [31:0] pc, i;
        logic [25:0] o26;
        int s12, s16, s26;
        string m;
        pc = b[63:32];
        i = b[31:0];
        o26 = {i[9:0], i[25:10]};
        s12 = int'(i[21:10]) - (i[21] ? 4096 : 0);
        s16 = int'(i[25:10]) - (i[25] ? 65536 : 0);
        s26 = int'(o26) - (o26[25] ? 67108864 : 0);
        m = "ILL";
        if (i[31:15] == 17'h20) m = "ADD";
        else if (i[31:15] == 17'h22) m = "SUB";
        else if (i[31:22] == 10'h00A) m = "ADDI";
        else if (i[31:22] == 10'h0A2) m = "LD";
        else if (i[31:22] == 10'h0A6) m = "ST";
        else if (i[31:25] == 7'h0A) m = "LU12I";
        else if (i[31:26] == 6'h14) m = "B";
        else if (i[31:26] == 6'h15) m = "BL";
        else if (i[31:26] == 6'h16) m = "BEQ";
        else if (i[31:26] == 6'h17) m = "BNE";
        else if (i[31:26] == 6'h13) m = "JIRL";
        e.a1 = i[9:5];
        e.a2 = (m == "ST" || m == "BEQ" || m == "BNE") ? i[4:0] : i[14:10];
        e.s1 = regs[e.a1];
        e.sd = regs[e.a2];
        e.rd = (m == "BL") ? 5'd1 : i[4:0];
        e.op = 0;
        e.s2 = e.sd;
        e.c2 = 1;
        e.we = 1;
        e.re = (m == "LD");
        e.wm = (m == "ST");
        e.ill = (m == "ILL");
        e.tk = 0;
        e.tgt = 0;
        case (m)
            "SUB": e.op = 1;
            "ADDI", "LD", "ST": e.s2 = 32'(s12);
            "LU12I": begin e.op = 2; e.s2 = 32'(i[24:5]) * 4096; end
            "BL": begin e.op = 2; e.s2 = pc + 4; e.tk = 1; e.tgt = pc + 32'(s26 * 4); end
            "B": begin e.c2 = 0; e.tk = 1; e.tgt = pc + 32'(s26 * 4); end
            "JIRL": begin e.op = 2; e.s2 = pc + 4; e.tk = 1; e.tgt = e.s1 + 32'(s16 * 4); end
            "BEQ", "BNE": begin
                e.c2 = 0;
                e.tk = (m == "BEQ") == (e.s1 == e.sd);
                e.tgt = pc + 32'(s16 * 4);
            end
            "ILL": e.c2 = 0;
            default: ;
        endcase
        if (m == "ST" || m == "B" || m == "BEQ" || m == "BNE" || m == "ILL") e.we = 0;
        return e;
    endfunction

    function automatic logic [63:0] gen();
        logic [31:0] r, i;
        r = $urandom;
        case ($urandom_range(0, 11))
            0: i = {17'h20, r[14:0]};
            1: i = {17'h22, r[14:0]};
            2: i = {10'h00A, r[21:0]};
            3: i = {10'h0A2, r[21:0]};
            4: i = {10'h0A6, r[21:0]};
            5: i = {7'h0A, r[24:0]};
            6: i = {6'h14, r[25:0]};
            7: i = {6'h15, r[25:0]};
            8: i = {6'h16, r[25:0]};
            9: i = {6'h17, r[25:0]};
            10: i = {6'h13, r[25:0]};
            default: i = r;
        endcase
        return {$urandom & 32'hFFFFFFFC, i};
    endfunction

    // one clock: decide acceptance at the falling edge, commit it at the rising edge
    task automatic step();
        @(negedge clk);
        acc = in_valid && in_ready && !is_branch && reset;
        drp = in_valid && is_branch;
        @(posedge clk);
        if (!reset) q.delete();
        else if (acc) q.push_back(in_bus);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic ev;
        if (armed) begin
            ev = q.size() != 0 && !hazard_stall;
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, q.size() == 0 || (ev && out_ready));
            if (ev) begin
                e = ref_model(q[0]);
                chk("out_pc", out_pc, q[0][63:32]);
                chk("rf_raddr1", rf_raddr1, e.a1);
                chk("rf_raddr2", rf_raddr2, e.a2);
                chk("out_src1", out_src1, e.s1);
                chk("out_st_data", out_st_data, e.sd);
                chk("out_rd", out_rd, e.rd);
                chk("flags", {out_rf_we, out_mem_re, out_mem_we, out_illegal}, {e.we, e.re, e.wm, e.ill});
                if (e.c2) begin
                    chk("out_alu_op", out_alu_op, e.op);
                    chk("out_src2", out_src2, e.s2);
                end
                if (out_ready) begin
                    chk("is_branch", is_branch, e.tk);
                    chk("flush", flush, e.tk);
                    if (e.tk) chk("dnpc", dnpc, e.tgt);
                    void'(q.pop_front());
                end else chk("is_branch_held", is_branch, 0);
            end else chk("is_branch_idle", is_branch, 0);
        end
    end

    initial begin
        bit pend;
        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        reset = 0; in_valid = 0; in_bus = '0; out_ready = 1; hazard_stall = 0;
        step(); armed = 1; step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_dnpc", dnpc, RESET_PC);
        chk("rst_out_pc", out_pc, RESET_PC);
        reset = 1;
        in_bus = {RESET_PC, 32'h00101885}; in_valid = 1; out_ready = 0;
        step();
        in_bus = {32'h1C000004, 10'h00A, 12'hFFF, 5'd7, 5'd8};
        chk("t1_out_valid", out_valid, 1);
        chk("t1_alu_op", out_alu_op, 0);
        chk("t1_rd", out_rd, 5);
        chk("t1_raddr1", rf_raddr1, 4);
        chk("t1_raddr2", rf_raddr2, 6);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_in_ready_low", in_ready, 0);
            chk("t2_pc_stable", out_pc, RESET_PC);
        end
        out_ready = 1;
        step();
        chk("t2_no_bubble_valid", out_valid, 1);
        chk("t2_no_bubble_pc", out_pc, 32'h1C000004);
        chk("t2_addi_src2", out_src2, 32'hFFFFFFFF);
        in_valid = 0;
        step();
        regs[1] = 7; regs[2] = 7;
        in_bus = {32'h1C000010, 6'h16, 16'd4, 5'd1, 5'd2}; in_valid = 1;
        step();
        in_bus = {32'h1C000014, 32'h00101885};
        chk("t3_is_branch", is_branch, 1);
        chk("t3_flush", flush, 1);
        chk("t3_dnpc", dnpc, 32'h1C000020);
        step();
        in_valid = 0;
        chk("t3_drop", out_valid, 0);
        chk("t3_pulse", is_branch, 0);
        regs[2] = 8;
        in_bus = {32'h1C000010, 6'h16, 16'd4, 5'd1, 5'd2}; in_valid = 1;
        step();
        in_valid = 0;
        chk("t3_not_taken", is_branch, 0);
        step();
        regs[2] = 32'h80000000;
        in_bus = {32'h1C000100, 6'h13, 16'hFFFF, 5'd2, 5'd1}; in_valid = 1;
        step();
        in_valid = 0;
        chk("t4_dnpc", dnpc, 32'h7FFFFFFC);
        chk("t4_src2", out_src2, 32'h1C000104);
        chk("t4_rd", out_rd, 1);
        step();
        hazard_stall = 1;
        in_bus = {32'h1C000200, 6'h14, 16'd8, 10'd0}; in_valid = 1;
        step();
        in_valid = 0;
        for (int k = 0; k < 2; k++) begin
            chk("t5_stall_valid", out_valid, 0);
            chk("t5_stall_branch", is_branch, 0);
            step();
        end
        hazard_stall = 0;
        #1;
        chk("t5_branch", is_branch, 1);
        chk("t5_dnpc", dnpc, 32'h1C000220);
        step();
        chk("t5_single_pulse", is_branch, 0);
        in_bus = {32'h1C000300, 32'hFFFFFFFF}; in_valid = 1;
        step();
        chk("t6_illegal", out_illegal, 1);
        chk("t6_we", out_rf_we, 0);
        chk("t6_no_branch", is_branch, 0);
        in_bus = {32'h1C000304, 7'h0A, 20'h12345, 5'd3};
        step();
        in_valid = 0;
        chk("t6_lu12i_src2", out_src2, 32'h12345000);
        chk("t6_lu12i_rd", out_rd, 3);
        step();
        for (int k = 0; k < 32; k++) regs[k] = k[0] ? 32'($urandom_range(0, 2)) : $urandom;
        pend = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = (c % 1000) != 999;
            if (!pend && $urandom_range(0, 9) < 7) begin
                in_bus = gen(); in_valid = 1; pend = 1;
            end
            out_ready = $urandom_range(0, 3) != 0;
            hazard_stall = $urandom_range(0, 6) == 0;
            regs[$urandom_range(0, 31)] = $urandom_range(0, 1) ? 32'($urandom_range(0, 2)) : $urandom;
            step();
            if (acc || drp) begin pend = 0; in_valid = 0; end
        end
        reset = 1; in_valid = 0; out_ready = 1; hazard_stall = 0;
        repeat (4) step();
        chk("drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
